// File: rtl/mode_button_if.sv
// Button-stage signal bundle: raw button in, debounced mode selection out.
//   btn       : raw push-button level (asynchronous to clk, may bounce)
//   mode      : current 2-bit mode selection
//   mode_stb  : one-cycle pulse on every mode update event
//   btn_level : debounced button level
interface mode_button_if;
  logic       btn;
  logic [1:0] mode;
  logic       mode_stb;
  logic       btn_level;

  // Consumer side: drives the button, observes the mode outputs.
  modport master (
    output btn,
    input  mode,
    input  mode_stb,
    input  btn_level
  );

  // Button stage side.
  modport slave (
    input  btn,
    output mode,
    output mode_stb,
    output btn_level
  );
endinterface

// File: rtl/mode_button.sv
// Push-button mode selector: synchronizes and debounces a raw button, then
// short press steps the mode (wrapping at NUM_MODES), long press forces mode 0.
// Ports:
//   clk   : system clock, all state on rising edge
//   reset : asynchronous active-low reset
//   bus   : mode_button_if.slave (btn in; mode, mode_stb, btn_level out)
module mode_button #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES     = 64,
  parameter int unsigned NUM_MODES       = 3
) (
  input  logic          clk,
  input  logic          reset,
  mode_button_if.slave  bus
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned MODE_W = 2;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_e;

  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic              stable_q, stable_d;
  logic              stable_dly_q, stable_dly_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              mode_stb_q, mode_stb_d;
  state_e            state_q, state_d;

  logic              rise_c;
  logic              fall_c;

  // Two-flop synchronizer for the asynchronous button.
  always_comb begin
    s1_d = bus.btn;
    s2_d = s1_q;
  end

  // Debouncer: a new level must persist DEBOUNCE_CYCLES cycles; any return
  // to the accepted level restarts the count.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    if (s2_q == stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      stable_d = s2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Edge detect on the debounced level.
  always_comb begin
    stable_dly_d = stable_q;
    rise_c       = stable_q & ~stable_dly_q;
    fall_c       = ~stable_q & stable_dly_q;
  end

  // Press FSM: fall is checked before hold expiry so the two never coincide.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    mode_d     = mode_q;
    mode_stb_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise_c) begin
          state_d    = PRESSED;
          hold_cnt_d = '0;
        end
      end
      PRESSED: begin
        if (fall_c) begin
          state_d    = IDLE;
          mode_d     = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);
          mode_stb_d = 1'b1;
        end else if (hold_cnt_q == HOLD_LAST) begin
          // Strobe even when mode is already 0 so downstream sees the event.
          state_d    = HELD;
          mode_d     = '0;
          mode_stb_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      HELD: begin
        if (fall_c) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      db_cnt_q     <= '0;
      hold_cnt_q   <= '0;
      mode_q       <= '0;
      mode_stb_q   <= 1'b0;
      state_q      <= IDLE;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      db_cnt_q     <= db_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      mode_q       <= mode_d;
      mode_stb_q   <= mode_stb_d;
      state_q      <= state_d;
    end
  end

  assign bus.mode      = mode_q;
  assign bus.mode_stb  = mode_stb_q;
  assign bus.btn_level = stable_q;

endmodule

// File: tb/tb_mode_button.sv
// Directed bench for mode_button (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, NUM_MODES=3).
module tb_mode_button;

  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 20;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   stb_total;
  int   stb_double;
  logic stb_prev;

  mode_button_if bif ();

  mode_button #(
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HOLD),
    .NUM_MODES       (3)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Pulse counter sampled on the falling edge, away from the active edge.
  initial begin
    stb_total  = 0;
    stb_double = 0;
    stb_prev   = 1'b0;
  end
  always @(negedge clk) begin
    if (bif.mode_stb === 1'b1) begin
      stb_total = stb_total + 1;
      if (stb_prev === 1'b1) stb_double = stb_double + 1;
    end
    stb_prev = bif.mode_stb;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bif.btn = 1'b0;
    rst_n   = 1'b0;
    step(2);
    rst_n   = 1'b1;
    step(2);
  endtask

  task automatic press(input int hold);
    bif.btn = 1'b1;
    step(hold);
    bif.btn = 1'b0;
    step(20);
  endtask

  task automatic test_reset();
    int base;
    bif.btn = 1'b1;
    rst_n   = 1'b0;
    #25;
    checks++; if (bif.mode !== 2'd0) begin errors++; $display("FAIL rst_mode got %0d exp 0", bif.mode); end
    checks++; if (bif.mode_stb !== 1'b0) begin errors++; $display("FAIL rst_stb got %b exp 0", bif.mode_stb); end
    checks++; if (bif.btn_level !== 1'b0) begin errors++; $display("FAIL rst_level got %b exp 0", bif.btn_level); end
    #26;
    rst_n = 1'b1;
    base  = stb_total;
    step(5);
    checks++; if (bif.btn_level !== 1'b0) begin errors++; $display("FAIL rst_level_early got %b exp 0", bif.btn_level); end
    step(1);
    checks++; if (bif.btn_level !== 1'b1) begin errors++; $display("FAIL rst_level_6 got %b exp 1", bif.btn_level); end
    bif.btn = 1'b0;
    step(DB + 2);
    checks++; if (bif.mode !== 2'd0 || bif.mode_stb !== 1'b0) begin errors++; $display("FAIL rst_rel_early mode %0d stb %b exp 0 0", bif.mode, bif.mode_stb); end
    step(1);
    checks++; if (bif.mode !== 2'd1 || bif.mode_stb !== 1'b1) begin errors++; $display("FAIL rst_rel mode %0d stb %b exp 1 1", bif.mode, bif.mode_stb); end
    step(1);
    checks++; if (bif.mode_stb !== 1'b0) begin errors++; $display("FAIL rst_rel_stb_off got %b exp 0", bif.mode_stb); end
    step(10);
    checks++; if (stb_total - base !== 1) begin errors++; $display("FAIL rst_pulses got %0d exp 1", stb_total - base); end
  endtask

  task automatic test_short_presses();
    logic [1:0] exp_mode [3];
    int base;
    exp_mode[0] = 2'd1;
    exp_mode[1] = 2'd2;
    exp_mode[2] = 2'd0;
    do_reset();
    base = stb_total;
    for (int i = 0; i < 3; i++) begin
      bif.btn = 1'b1;
      step(10);
      bif.btn = 1'b0;
      step(DB + 2);
      checks++; if (bif.mode_stb !== 1'b0) begin errors++; $display("FAIL short%0d_stb_early got %b exp 0", i, bif.mode_stb); end
      step(1);
      checks++; if (bif.mode !== exp_mode[i] || bif.mode_stb !== 1'b1) begin errors++; $display("FAIL short%0d mode %0d stb %b exp %0d 1", i, bif.mode, bif.mode_stb, exp_mode[i]); end
      step(1);
      checks++; if (bif.mode_stb !== 1'b0) begin errors++; $display("FAIL short%0d_stb_off got %b exp 0", i, bif.mode_stb); end
      step(12);
    end
    checks++; if (stb_total - base !== 3) begin errors++; $display("FAIL short_pulses got %0d exp 3", stb_total - base); end
  endtask

  task automatic test_bounce();
    int   base;
    logic saw_level;
    base      = stb_total;
    saw_level = 1'b0;
    bif.btn   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bif.btn = ~bif.btn;
      step(1);
      if (bif.btn_level !== 1'b0) saw_level = 1'b1;
      step(1);
      if (bif.btn_level !== 1'b0) saw_level = 1'b1;
    end
    bif.btn = 1'b0;
    step(10);
    checks++; if (saw_level !== 1'b0) begin errors++; $display("FAIL bounce_level got %b exp 0", saw_level); end
    checks++; if (bif.mode !== 2'd0) begin errors++; $display("FAIL bounce_mode got %0d exp 0", bif.mode); end
    checks++; if (stb_total - base !== 0) begin errors++; $display("FAIL bounce_pulses got %0d exp 0", stb_total - base); end
  endtask

  task automatic test_bounce_settle();
    int base;
    base = stb_total;
    for (int i = 0; i < 3; i++) begin
      bif.btn = 1'b1;
      step(1);
      bif.btn = 1'b0;
      step(2);
    end
    checks++; if (bif.btn_level !== 1'b0) begin errors++; $display("FAIL settle_glitch_level got %b exp 0", bif.btn_level); end
    press(12);
    checks++; if (bif.mode !== 2'd1) begin errors++; $display("FAIL settle_mode got %0d exp 1", bif.mode); end
    checks++; if (stb_total - base !== 1) begin errors++; $display("FAIL settle_pulses got %0d exp 1", stb_total - base); end
  endtask

  task automatic test_long_press();
    int base;
    press(10);
    checks++; if (bif.mode !== 2'd2) begin errors++; $display("FAIL long_pre_mode got %0d exp 2", bif.mode); end
    base    = stb_total;
    bif.btn = 1'b1;
    step(DB + 2 + HOLD);
    checks++; if (bif.mode !== 2'd2 || bif.mode_stb !== 1'b0) begin errors++; $display("FAIL long_early mode %0d stb %b exp 2 0", bif.mode, bif.mode_stb); end
    step(1);
    checks++; if (bif.mode !== 2'd0 || bif.mode_stb !== 1'b1) begin errors++; $display("FAIL long_expiry mode %0d stb %b exp 0 1", bif.mode, bif.mode_stb); end
    step(33);
    bif.btn = 1'b0;
    step(20);
    checks++; if (bif.mode !== 2'd0) begin errors++; $display("FAIL long_release_mode got %0d exp 0", bif.mode); end
    checks++; if (stb_total - base !== 1) begin errors++; $display("FAIL long_pulses got %0d exp 1", stb_total - base); end
  endtask

  task automatic test_reset_mid_press();
    int base;
    press(10);
    checks++; if (bif.mode !== 2'd1) begin errors++; $display("FAIL mid_pre_mode got %0d exp 1", bif.mode); end
    bif.btn = 1'b1;
    step(DB + 4);
    #3;
    rst_n = 1'b0;
    #2;
    checks++; if (bif.mode !== 2'd0 || bif.btn_level !== 1'b0) begin errors++; $display("FAIL mid_async mode %0d level %b exp 0 0", bif.mode, bif.btn_level); end
    step(2);
    rst_n = 1'b1;
    base  = stb_total;
    step(10);
    checks++; if (bif.btn_level !== 1'b1 || bif.mode !== 2'd0) begin errors++; $display("FAIL mid_redebounce level %b mode %0d exp 1 0", bif.btn_level, bif.mode); end
    bif.btn = 1'b0;
    step(DB + 3);
    checks++; if (bif.mode !== 2'd1 || bif.mode_stb !== 1'b1) begin errors++; $display("FAIL mid_release mode %0d stb %b exp 1 1", bif.mode, bif.mode_stb); end
    step(10);
    checks++; if (stb_total - base !== 1) begin errors++; $display("FAIL mid_pulses got %0d exp 1", stb_total - base); end
  endtask

  task automatic test_no_double_strobe();
    checks++; if (stb_double !== 0) begin errors++; $display("FAIL stb_double got %0d exp 0", stb_double); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    bif.btn = 1'b0;
    rst_n   = 1'b0;
    test_reset();
    test_short_presses();
    test_bounce();
    test_bounce_settle();
    test_long_press();
    test_reset_mid_press();
    test_no_double_strobe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mode_button.md
# mode_button

Upstream input stage for the LED pattern generator. Turns one raw, bouncing push-button into a clean 2-bit `mode` selection and a one-cycle strobe. Short press steps through the modes; long press returns to mode 0. `mode` drives the pattern generator's `mode[1:0]` input directly.

## Interface
- `DEBOUNCE_CYCLES`, 16 — consecutive cycles a synchronized level must hold before it is accepted (board build: 1_000_000 at 50 MHz); range ≥2.
- `HOLD_CYCLES`, 64 — cycles of accepted-press before it counts as a long press; must be > 1.
- `NUM_MODES`, 3 — number of modes in the cycle; range 2..4.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn`  in  1  raw push-button, asynchronous to `clk`, active-high, may bounce.
- `mode`  out  2  current mode, registered, 0..NUM_MODES-1.
- `mode_stb`  out  1  one-cycle pulse on every mode update event.
- `btn_level`  out  1  debounced button level, registered (debug/LED use).

## Operation
- Synchronizer: two flops `btn` → `s1` → `s2`; both reset to 0.
- Debouncer: registers `stable` (= `btn_level`) and counter `db_cnt`.
  - `s2 == stable`: `db_cnt` ← 0.
  - `s2 != stable` and `db_cnt == DEBOUNCE_CYCLES-1`: `stable` ← `s2`, `db_cnt` ← 0.
  - Otherwise `db_cnt` increments.
  - Any glitch back to `stable` before acceptance restarts the count.
- Edge detect: `stable_d` is a one-cycle delayed `stable`.
  - rise = `stable & ~stable_d`
  - fall = `~stable & stable_d`
- FSM states: IDLE, PRESSED, HELD. Counter `hold_cnt` is sized for HOLD_CYCLES.
  - IDLE: on rise → PRESSED, `hold_cnt` ← 0.
  - PRESSED, fall → IDLE.
    - `mode` ← `mode+1`, wrapping NUM_MODES-1 → 0.
    - `mode_stb` ← 1.
  - PRESSED, no fall, `hold_cnt == HOLD_CYCLES-1` → HELD.
    - `mode` ← 0, `mode_stb` ← 1.
    - The strobe fires even if `mode` is already 0.
  - PRESSED otherwise: `hold_cnt` increments.
  - HELD: on fall → IDLE; no mode change, no strobe.
  - Fall and hold expiry never coincide: fall is checked first.
- `mode_stb` is registered and high for exactly one cycle per event. It is never high two consecutive cycles.
- Mode arithmetic is 2-bit. With NUM_MODES=4 the wrap is the natural overflow 3 → 0.
- Reset (reset=0, any time, including mid-press or mid-debounce), asynchronously:
  - `s1`, `s2`, `stable`, `stable_d`, `db_cnt`, `hold_cnt` = 0.
  - FSM = IDLE, `mode` = 0, `mode_stb` = 0, `btn_level` = 0.
- Button held across reset release: it is re-debounced as a fresh press. Its release then advances the mode.

## Timing
- `btn` rises cleanly, first sampled at edge E0:
  - `s2` = 1 after edge E1.
  - `stable` = 1 after edge E1+DEBOUNCE_CYCLES.
  - FSM = PRESSED one edge later.
- `btn` falls cleanly, first sampled at edge F0:
  - `stable` = 0 after F1+DEBOUNCE_CYCLES.
  - `mode` and `mode_stb` update on the next edge, DEBOUNCE_CYCLES+2 edges after F0.
- Long press: `mode` ← 0 and `mode_stb` pulse occur HOLD_CYCLES edges after FSM enters PRESSED.
- Bounces shorter than DEBOUNCE_CYCLES produce no change in `btn_level`, `mode` or `mode_stb`.
- No combinational path from any input to any output.

## Test plan
(DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, NUM_MODES=3, 20 ns clock.)
- Reset: reset=0 for 50 ns with btn=1, then reset=1.
  - During reset: `mode`=0, `mode_stb`=0, `btn_level`=0.
  - After release: `btn_level`=1 six edges later.
- Short presses: three clean presses of 10 cycles each, 20 cycles apart.
  - `mode` steps 0→1→2→0.
  - Exactly three `mode_stb` pulses, each DEBOUNCE_CYCLES+2 edges after a release.
- Bounce rejection: btn toggles every 2 cycles for 40 cycles, then returns to 0.
  - `btn_level` stays 0, `mode` unchanged, no `mode_stb`.
- Bounce then settle: 3 short glitches, then btn=1 held 12 cycles, then clean release.
  - Exactly one mode increment.
- Long press from `mode`=2: btn held 60 cycles.
  - `mode`=0 with one `mode_stb` at hold expiry.
  - Release gives no further strobe; `mode` stays 0.
- Reset mid-press: reset=0 while FSM=PRESSED and `mode`=1.
  - `mode`=0 immediately (asynchronous).
  - The subsequent release of the still-held button yields `mode`=1 and one strobe.
